// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner
//
// Sequencer that drives a 16:1 enabled mux. Starting from channel 0 it walks
// every channel in order. A channel whose mask bit is set is driven for SETTLE
// cycles, then sampled for one CAPTURE cycle. A masked-off channel spends a
// single SKIP cycle with the mux disabled. When channel 15 is done, the
// collected 16-bit word is held on a valid/ready handshake until downstream
// accepts it.
//
// Parameters
//   NUM_CH    channel count (16, matching the 4-bit select)
//   SETTLE    cycles a channel is driven before it is sampled (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin a scan; only looked at while idle
//   chan_mask  in   [15:0] bit c set = scan channel c; latched on start
//   mux_v      in   mux output for the channel currently on sel
//   sel        out  [3:0] channel index driven to the mux
//   mux_en     out  mux enable, high while settling or capturing
//   busy       out  high whenever the scanner is not idle
//   result     out  [15:0] captured bits; masked channels read 0
//   out_valid  out  result word complete and stable
//   out_ready  in   downstream accepts result while out_valid is high
module mux_channel_scanner #(
    parameter int NUM_CH = 16,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] chan_mask,
    input  logic        mux_v,
    output logic [3:0]  sel,
    output logic        mux_en,
    output logic        busy,
    output logic [15:0] result,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SKIP,
        ST_HOLD
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] LAST_CH     = 4'(NUM_CH - 1);

    state_t      state, state_next;
    logic [3:0]  ch, ch_next;
    logic [3:0]  cnt, cnt_next;
    logic [15:0] mask, mask_next;
    logic [15:0] result_q, result_next;
    logic [3:0]  ch_plus;

    // State register. Reset abandons any scan in flight and clears the word,
    // so a partial result is never presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ch       <= 4'd0;
            cnt      <= 4'd0;
            mask     <= 16'd0;
            result_q <= 16'd0;
        end else begin
            state    <= state_next;
            ch       <= ch_next;
            cnt      <= cnt_next;
            mask     <= mask_next;
            result_q <= result_next;
        end
    end

    assign ch_plus = ch + 4'd1;

    // Next-state logic. CAPTURE and SKIP share one advance rule: stop after
    // channel 15 (the counter never wraps), otherwise step to the next
    // channel and choose SETTLE or SKIP from its mask bit.
    always_comb begin
        state_next  = state;
        ch_next     = ch;
        cnt_next    = cnt;
        mask_next   = mask;
        result_next = result_q;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    mask_next   = chan_mask;
                    ch_next     = 4'd0;
                    cnt_next    = 4'd0;
                    result_next = 16'd0;
                    state_next  = chan_mask[0] ? ST_SETTLE : ST_SKIP;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = 4'd0;
                    state_next = ST_CAPTURE;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ST_CAPTURE, ST_SKIP: begin
                if (state == ST_CAPTURE) begin
                    result_next[ch] = mux_v;
                end
                if (ch == LAST_CH) begin
                    state_next = ST_HOLD;
                end else begin
                    ch_next    = ch_plus;
                    state_next = mask[ch_plus] ? ST_SETTLE : ST_SKIP;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from the registered state, so sel only moves
    // when the channel register steps to a new channel.
    assign sel       = ch;
    assign mux_en    = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign result    = result_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb_mux_channel_scanner
//
// Self-checking bench for mux_channel_scanner. A reference model builds the
// expected per-cycle timeline of a scan from the channel costs: SETTLE+1
// cycles for a scanned channel and 1 cycle for a skipped one. From that it
// derives the expected sel, mux_en, latency and result word. Each test
// task compares the DUT against that model.
module tb_mux_channel_scanner;

    localparam int SETTLE = 2;
    localparam int MAXK   = 320;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] chan_mask;
    logic        mux_v;
    logic [3:0]  sel;
    logic        mux_en;
    logic        busy;
    logic [15:0] result;
    logic        out_valid;
    logic        out_ready;

    int vectors     = 0;
    int miscompares = 0;

    // Model timeline, indexed by cycle number after the accepting edge.
    logic [3:0]  exp_sel [0:MAXK];
    logic        exp_en  [0:MAXK];
    logic        vpat    [0:MAXK];
    int          exp_total;
    logic [15:0] exp_res;

    // Observed timeline from the last scan.
    logic [3:0]  obs_sel [0:MAXK];
    logic        obs_en  [0:MAXK];
    int          obs_lat;
    logic [15:0] obs_res;

    mux_channel_scanner #(.NUM_CH(16), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .chan_mask (chan_mask),
        .mux_v     (mux_v),
        .sel       (sel),
        .mux_en    (mux_en),
        .busy      (busy),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Builds the expected timeline for one scan. Channel c occupies a span of
    // cycles, and it is sampled in the last cycle of that span.
    // mode 0: random mux_v, 1: mux_v = channel parity,
    // mode 2: mux_v = 1, 3: mux_v toggles every cycle.
    function automatic void build_model(input logic [15:0] m, input int mode);
        int k;
        int cost;
        k = 1;
        exp_res = 16'd0;
        for (int i = 0; i <= MAXK; i++) begin
            vpat[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 16; c++) begin
            cost = m[c] ? SETTLE + 1 : 1;
            for (int j = 0; j < cost; j++) begin
                exp_sel[k] = 4'(c);
                exp_en[k]  = m[c];
                case (mode)
                    1:       vpat[k] = 1'(c % 2);
                    2:       vpat[k] = 1'b1;
                    3:       vpat[k] = 1'(k % 2);
                    default: ;
                endcase
                k++;
            end
            if (m[c]) exp_res[c] = vpat[k-1];
        end
        exp_total = k - 1;
    endfunction

    // Starts a scan with the given mask and drives mux_v from the model's
    // pattern. It records sel/mux_en each cycle until out_valid rises or the
    // cycle budget runs out (obs_lat = -1).
    task automatic run_scan(input logic [15:0] m, input int mode);
        build_model(m, mode);
        @(negedge clk);
        chan_mask = m;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        obs_lat = -1;
        for (int k = 1; k < MAXK; k++) begin
            mux_v      = vpat[k];
            obs_sel[k] = sel;
            obs_en[k]  = mux_en;
            @(posedge clk);
            #1;
            if (out_valid) begin
                obs_lat = k;
                break;
            end
        end
        obs_res = result;
    endtask

    task automatic test_reset;
        bit seen;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; mux_v = 1'b1; chan_mask = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({sel, mux_en, busy, out_valid, result} !== 24'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got sel=%0d en=%b busy=%b valid=%b result=%h, want all 0",
                     sel, mux_en, busy, out_valid, result);
        end
        rst = 1'b0;
        @(negedge clk);
        chan_mask = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1 || result === 16'd0) begin
            miscompares++;
            $display("[TB] FAIL midscan_busy: got busy=%b result=%h, want busy=1 result!=0", busy, result);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({sel, mux_en, busy, out_valid, result} !== 24'd0) begin
                miscompares++;
                $display("[TB] FAIL midscan_reset: got sel=%0d en=%b busy=%b valid=%b result=%h, want all 0",
                         sel, mux_en, busy, out_valid, result);
            end
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_partial_result: got valid/busy activity=%b, want 0", seen);
        end
    endtask

    task automatic test_full_mask;
        out_ready = 1'b0;
        run_scan(16'hFFFF, 1);
        vectors++;
        if (obs_lat !== 48) begin
            miscompares++;
            $display("[TB] FAIL full_latency: got %0d, want 48", obs_lat);
        end
        vectors++;
        if (obs_res !== 16'hAAAA) begin
            miscompares++;
            $display("[TB] FAIL full_result: got %h, want aaaa", obs_res);
        end
        for (int k = 1; k <= 48; k++) begin
            vectors++;
            if (obs_sel[k] !== exp_sel[k] || obs_en[k] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL full_seq cycle %0d: got sel=%0d en=%b, want sel=%0d en=1",
                         k, obs_sel[k], obs_en[k], exp_sel[k]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_release: got valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_sparse;
        out_ready = 1'b0;
        run_scan(16'h8001, 2);
        vectors++;
        if (obs_lat !== 20) begin
            miscompares++;
            $display("[TB] FAIL sparse_latency: got %0d, want 20", obs_lat);
        end
        vectors++;
        if (obs_res !== 16'h8001) begin
            miscompares++;
            $display("[TB] FAIL sparse_result: got %h, want 8001", obs_res);
        end
        for (int k = 1; k <= exp_total; k++) begin
            vectors++;
            if (obs_en[k] !== exp_en[k] || obs_sel[k] !== exp_sel[k]) begin
                miscompares++;
                $display("[TB] FAIL sparse_seq cycle %0d: got sel=%0d en=%b, want sel=%0d en=%b",
                         k, obs_sel[k], obs_en[k], exp_sel[k], exp_en[k]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_zero_mask;
        bit en_seen;
        out_ready = 1'b0;
        run_scan(16'h0000, 2);
        vectors++;
        if (obs_lat !== 16) begin
            miscompares++;
            $display("[TB] FAIL zero_latency: got %0d, want 16", obs_lat);
        end
        vectors++;
        if (obs_res !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL zero_result: got %h, want 0000", obs_res);
        end
        en_seen = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (obs_en[k] !== 1'b0) en_seen = 1'b1;
        end
        vectors++;
        if (en_seen !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_mux_en: got asserted=%b, want 0", en_seen);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_pressure;
        logic [15:0] m;
        out_ready = 1'b0;
        m = 16'($urandom) | 16'h0010;
        run_scan(m, 0);
        vectors++;
        if (obs_lat !== exp_total || obs_res !== exp_res) begin
            miscompares++;
            $display("[TB] FAIL bp_scan: got lat=%0d res=%h, want lat=%0d res=%h",
                     obs_lat, obs_res, exp_total, exp_res);
        end
        for (int i = 0; i < 10; i++) begin
            start = (i % 3 == 0);
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || result !== exp_res) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b busy=%b res=%h, want 1 1 %h",
                         i, out_valid, busy, result, exp_res);
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got valid=%b busy=%b res=%h, want 0 0 %h",
                     out_valid, busy, result, exp_res);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_start_not_queued: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_ready_held;
        out_ready = 1'b1;
        run_scan(16'($urandom), 0);
        vectors++;
        if (obs_lat !== exp_total || obs_res !== exp_res) begin
            miscompares++;
            $display("[TB] FAIL ready_held_scan: got lat=%0d res=%h, want lat=%0d res=%h",
                     obs_lat, obs_res, exp_total, exp_res);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_held_one_cycle: got valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_start_ignored: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_random_scans;
        logic [15:0] m;
        for (int t = 0; t < 8; t++) begin
            out_ready = 1'b0;
            m = 16'($urandom);
            run_scan(m, (t % 2 == 0) ? 3 : 0);
            vectors++;
            if (obs_lat !== exp_total) begin
                miscompares++;
                $display("[TB] FAIL rand_latency mask=%h: got %0d, want %0d", m, obs_lat, exp_total);
            end
            vectors++;
            if (obs_res !== exp_res) begin
                miscompares++;
                $display("[TB] FAIL rand_result mask=%h: got %h, want %h", m, obs_res, exp_res);
            end
            for (int k = 1; k <= exp_total; k++) begin
                vectors++;
                if (obs_sel[k] !== exp_sel[k] || obs_en[k] !== exp_en[k]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_seq mask=%h cycle %0d: got sel=%0d en=%b, want sel=%0d en=%b",
                             m, k, obs_sel[k], obs_en[k], exp_sel[k], exp_en[k]);
                end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse();
        test_zero_mask();
        test_back_pressure();
        test_ready_held();
        test_random_scans();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
